// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one byte-level SPI controller among N_REQ requesters.
// Each grant runs one multi-byte transaction; the controller is reprogrammed only when the config changes.
module spi_arbiter #(
  parameter int N_REQ    = 2,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*10-1:0]    i_req_config,
  input  logic [N_REQ*LEN_W-1:0] i_req_len,
  input  logic [N_REQ*8-1:0]     i_tx,
  input  logic [N_REQ-1:0]       i_tx_valid,
  output logic [N_REQ-1:0]       o_tx_ack,
  output logic [N_REQ-1:0]       o_grant,
  output logic [7:0]             o_rx,
  output logic                   o_rx_valid,
  output logic                   o_done,
  output logic [N_REQ-1:0]       o_cs_n,
  output logic [10:0]            o_spi_config,
  output logic [7:0]             o_spi_tx,
  output logic                   o_spi_tx_valid,
  input  logic [7:0]             i_spi_rx,
  input  logic                   i_spi_rx_valid,
  input  logic                   i_spi_ready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_CFG_WAIT, S_CS_SETUP, S_LOAD, S_XFER, S_CS_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      gnt_q, gnt_d;
  logic [9:0]         cfg_q, cfg_d;
  logic [9:0]         cur_cfg_q, cur_cfg_d;
  logic               cfg_loaded_q, cfg_loaded_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         timer_q, timer_d;
  logic               seen_low_q, seen_low_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   cs_n_q, cs_n_d;
  logic [N_REQ-1:0]   tx_ack_q, tx_ack_d;
  logic [7:0]         rx_q, rx_d;
  logic               rx_valid_q, rx_valid_d;
  logic               done_q, done_d;
  logic [10:0]        spi_config_q, spi_config_d;
  logic [7:0]         spi_tx_q, spi_tx_d;
  logic               spi_tx_valid_q, spi_tx_valid_d;

  logic               arb_found;
  logic [IW-1:0]      arb_idx;
  logic [9:0]         sel_cfg;

  // Search starts one past the last winner, so a held request waits for all others.
  always_comb begin
    int c;
    arb_found = 1'b0;
    arb_idx   = '0;
    c         = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      c = (int'(rr_q) + i) % N_REQ;
      if (!arb_found && i_req[c]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(c);
      end
    end
  end

  // NOTE: every next-state variable gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    gnt_d          = gnt_q;
    cfg_d          = cfg_q;
    cur_cfg_d      = cur_cfg_q;
    cfg_loaded_d   = cfg_loaded_q;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    seen_low_d     = seen_low_q;
    grant_d        = grant_q;
    cs_n_d         = cs_n_q;
    tx_ack_d       = '0;
    rx_d           = rx_q;
    rx_valid_d     = 1'b0;
    done_d         = 1'b0;
    spi_config_d   = '0;
    spi_tx_d       = spi_tx_q;
    spi_tx_valid_d = 1'b0;
    sel_cfg        = i_req_config[int'(arb_idx)*10 +: 10];

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          gnt_d          = arb_idx;
          rr_d           = arb_idx;
          cfg_d          = sel_cfg;
          cnt_d          = i_req_len[int'(arb_idx)*LEN_W +: LEN_W];
          grant_d        = '0;
          grant_d[arb_idx] = 1'b1;
          timer_d        = '0;
          state_d        = (!cfg_loaded_q || sel_cfg != cur_cfg_q) ? S_CONFIG : S_CS_SETUP;
        end
      end
      S_CONFIG: begin
        if (i_spi_ready) begin
          spi_config_d = {cfg_q, 1'b1};
          cur_cfg_d    = cfg_q;
          cfg_loaded_d = 1'b1;
          timer_d      = '0;
          seen_low_d   = 1'b0;
          state_d      = S_CFG_WAIT;
        end
      end
      S_CFG_WAIT: begin
        // Leave only after the controller has dropped and restored ready, and never before 2 cycles.
        if (timer_q != 8'hFF) timer_d = timer_q + 8'd1;
        if (!i_spi_ready) seen_low_d = 1'b1;
        if (seen_low_q && i_spi_ready && timer_q >= 8'd1) begin
          timer_d = '0;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        cs_n_d        = '1;
        cs_n_d[gnt_q] = 1'b0;
        if (timer_q == 8'(CS_SETUP - 1)) begin
          timer_d = '0;
          state_d = S_LOAD;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_LOAD: begin
        if (i_tx_valid[gnt_q] && i_spi_ready) begin
          spi_tx_d        = i_tx[int'(gnt_q)*8 +: 8];
          spi_tx_valid_d  = 1'b1;
          tx_ack_d[gnt_q] = 1'b1;
          state_d         = S_XFER;
        end
      end
      S_XFER: begin
        if (i_spi_rx_valid) begin
          rx_d       = i_spi_rx;
          rx_valid_d = 1'b1;
          // Test before decrementing so a full-length transaction never wraps the counter.
          if (cnt_q == '0) begin
            timer_d = '0;
            state_d = S_CS_HOLD;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_CS_HOLD: begin
        if (timer_q == 8'(CS_HOLD - 1)) begin
          cs_n_d  = '1;
          done_d  = 1'b1;
          grant_d = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous; every flop is cleared so a mid-transaction reset aborts cleanly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      rr_q           <= IW'(N_REQ - 1);
      gnt_q          <= '0;
      cfg_q          <= '0;
      cur_cfg_q      <= '0;
      cfg_loaded_q   <= 1'b0;
      cnt_q          <= '0;
      timer_q        <= '0;
      seen_low_q     <= 1'b0;
      grant_q        <= '0;
      cs_n_q         <= '1;
      tx_ack_q       <= '0;
      rx_q           <= '0;
      rx_valid_q     <= 1'b0;
      done_q         <= 1'b0;
      spi_config_q   <= '0;
      spi_tx_q       <= '0;
      spi_tx_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      gnt_q          <= gnt_d;
      cfg_q          <= cfg_d;
      cur_cfg_q      <= cur_cfg_d;
      cfg_loaded_q   <= cfg_loaded_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      seen_low_q     <= seen_low_d;
      grant_q        <= grant_d;
      cs_n_q         <= cs_n_d;
      tx_ack_q       <= tx_ack_d;
      rx_q           <= rx_d;
      rx_valid_q     <= rx_valid_d;
      done_q         <= done_d;
      spi_config_q   <= spi_config_d;
      spi_tx_q       <= spi_tx_d;
      spi_tx_valid_q <= spi_tx_valid_d;
    end
  end

  assign o_tx_ack       = tx_ack_q;
  assign o_grant        = grant_q;
  assign o_rx           = rx_q;
  assign o_rx_valid     = rx_valid_q;
  assign o_done         = done_q;
  assign o_cs_n         = cs_n_q;
  assign o_spi_config   = spi_config_q;
  assign o_spi_tx       = spi_tx_q;
  assign o_spi_tx_valid = spi_tx_valid_q;

endmodule
